obi_instr_fetch_bridge: RTL and testbench
=========================================

Name: obi_instr_fetch_bridge

Overview:
- Sits between the core's OBI instruction-fetch port and the port A (instruction port) of the testbench dual-port RAM.
- Converts the core's OBI request/grant/rvalid protocol into RAM enable/address signals and extracts one 32-bit fetch word from the wide RAM read line.
- Can inject pseudo-random grant stalls with a guaranteed upper bound on stall length, so the core's fetch stage is stressed.

Parameters:
- ADDR_WIDTH, 22, width of the RAM byte address.
- INSTR_RDATA_WIDTH, 128, width of the RAM port-A read line; minimum 64, multiple of 32.
- MAX_STALL, 3, maximum consecutive cycles in which gnt is withheld for a pending request; range 1..15.
- LFSR_SEED, 16'hACE1, reset value of the stall LFSR; must be non-zero.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- instr_req_i  in  1  OBI fetch request.
- instr_addr_i  in  32  OBI fetch byte address; halfword aligned.
- instr_gnt_o  out  1  OBI grant.
- instr_rvalid_o  out  1  OBI response valid.
- instr_rdata_o  out  32  fetch word.
- instr_err_o  out  1  response error; asserted with rvalid for an out-of-range address.
- stall_en_i  in  1  enables random grant stalls; sampled every cycle.
- ram_en_o  out  1  RAM port-A enable.
- ram_addr_o  out  ADDR_WIDTH  RAM port-A byte address.
- ram_rdata_i  in  INSTR_RDATA_WIDTH  RAM port-A read line; registered by the RAM, 1-cycle latency.
- gnt_count_o  out  32  count of granted requests; wraps on overflow.

Behaviour:
- Reset values:
  - gnt, rvalid, err, ram_en_o: 0.
  - instr_rdata_o, ram_addr_o, gnt_count_o: 0.
  - LFSR = LFSR_SEED; stall counter = 0.
- RAM interface:
  - The RAM reads on every clock edge regardless of enable.
  - On a grant cycle, ram_addr_o = {instr_addr_i[ADDR_WIDTH-1:2], 2'b00}, combinational from instr_addr_i.
  - On all other cycles, ram_addr_o holds the last granted value from a register.
  - ram_en_o = instr_gnt_o.
- Grant:
  - instr_gnt_o = instr_req_i & ~stall_now.
  - stall_now = stall_en_i & lfsr[0] & (stall_cnt < MAX_STALL).
- Stall counter:
  - Increments on every cycle with instr_req_i & ~instr_gnt_o.
  - Clears on grant, or when instr_req_i = 0.
  - This guarantees a grant within MAX_STALL+1 cycles of a request being raised.
- LFSR:
  - 16-bit Fibonacci, taps 16, 14, 13, 11.
  - Advances every cycle while stall_en_i = 1; holds otherwise.
- Response pipeline (one entry):
  - On a grant in cycle N, register: valid, addr[1], out-of-range flag (instr_addr_i >= 2**ADDR_WIDTH, using the full 32-bit compare).
  - In cycle N+1: instr_rvalid_o = 1.
  - rdata = ram_rdata_i[31:0] when the registered addr[1] = 0; ram_rdata_i[47:16] when addr[1] = 1. This serves a misaligned compressed/32-bit fetch from a single line.
  - Out-of-range: rdata = 32'h0000_0000 and err = 1.
  - Back-to-back grants give back-to-back rvalids, in order.
  - The OBI fetch port has no rready; a response is never delayed, so a new grant is always legal.
- instr_rdata_o:
  - Combinational when rvalid = 1.
  - Holds the last returned value when rvalid = 0, via a holding register.
- instr_addr_i[0] = 1 is a protocol violation: an SVA assertion fires; the bridge behaves as if bit 0 were 0.
- gnt_count_o increments on every grant; 32'hFFFF_FFFF wraps to 0.
- Reset mid-operation:
  - A pending response is dropped; no rvalid follows reset.
  - The LFSR reloads LFSR_SEED.

Decomposition:
- Package tb_mem_pkg:
  - OBI fetch request/response structs.
  - LFSR_TAPS constant.
  - Function for the line-slice offset: addr[1] * 16.
- One sub-module, tb_stall_lfsr: holds the LFSR, the stall counter, and the stall_now output. It is reusable for the data-port bridge.

Test Plan:
- No stall, reset RAM preloaded with word 0x0000_0000 = 32'h0010_0093 and word 0x4 = 32'h0000_0013.
  - Stimulus: req with addr 0x0 and 0x4 on consecutive cycles.
  - Required: gnt in both request cycles; rvalid in the two following cycles; rdata 32'h0010_0093 then 32'h0000_0013; gnt_count_o = 2.
- Misaligned fetch, RAM bytes 0x0..0x7 = 11 22 33 44 55 66 77 88.
  - Stimulus: req with addr 0x2.
  - Required: ram_addr_o = 0x0; rdata = 32'h6655_4433.
- Stall bound.
  - Stimulus: stall_en_i = 1, MAX_STALL = 3, req held for 1000 requests.
  - Required: the gap from req to gnt never exceeds 4 cycles; at least one stall occurs; the rvalid count equals the gnt count.
- Out-of-range.
  - Stimulus: ADDR_WIDTH = 22, req with addr 0x0040_0000.
  - Required: rvalid with err = 1 and rdata = 0.
  - Next in-range fetch: err = 0.
- Reset mid-operation.
  - Stimulus: assert rst_i in the cycle after a grant.
  - Required: no rvalid is produced; gnt_count_o = 0; the first post-reset stall pattern matches the seed-derived sequence.
- Counter wrap.
  - Stimulus: force gnt_count to 32'hFFFF_FFFF, then grant once.
  - Required: gnt_count_o = 0.

Source files
------------

// File: rtl/tb_mem_pkg.sv
// Shared types and constants for the testbench-memory OBI bridges.
//   obi_fetch_req_t / obi_fetch_rsp_t : OBI instruction-fetch request/response bundles
//   LFSR_TAPS                          : feedback mask of the 16-bit stall LFSR (taps 16,14,13,11)
//   line_slice_offset()                : bit offset of the fetch word inside a RAM read line
package tb_mem_pkg;

  // Bits 15, 13, 12 and 10 of the register correspond to taps 16, 14, 13 and 11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
  } obi_fetch_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } obi_fetch_rsp_t;

  // A fetch at addr[1] = 1 starts one halfword into the line: offset addr[1] * 16.
  function automatic int unsigned line_slice_offset(input logic addr1);
    return {27'd0, addr1, 4'd0};
  endfunction

endpackage

// File: rtl/tb_stall_lfsr.sv
// Pseudo-random grant-stall generator with a bounded stall length.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   stall_en_i    : enables stalls; the LFSR advances only while this is high
//   req_i         : a request is pending this cycle
//   stall_now_o   : withhold the grant this cycle
// A pending request is stalled for at most MAX_STALL consecutive cycles.
module tb_stall_lfsr
  import tb_mem_pkg::*;
#(
  parameter int unsigned MAX_STALL = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stall_en_i,
  input  logic req_i,
  output logic stall_now_o
);

  localparam logic [3:0] MAX_STALL_C = 4'(MAX_STALL);

  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  stall_cnt_q, stall_cnt_d;
  logic        stall_now;

  always_comb begin
    stall_now   = stall_en_i & lfsr_q[0] & (stall_cnt_q < MAX_STALL_C);
    lfsr_d      = stall_en_i ? {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)} : lfsr_q;
    // A stalled request is exactly req & stall_now; anything else (grant or no request) clears.
    stall_cnt_d = (req_i & stall_now) ? stall_cnt_q + 4'd1 : 4'd0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q      <= LFSR_SEED;
      stall_cnt_q <= 4'd0;
    end else begin
      lfsr_q      <= lfsr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_now_o = stall_now;

endmodule

// File: rtl/obi_instr_fetch_bridge.sv
// OBI instruction-fetch port to testbench dual-port RAM port A.
//   clk_i, rst_i                        : clock, asynchronous active-high reset
//   instr_req_i, instr_addr_i           : OBI fetch request, halfword-aligned byte address
//   instr_gnt_o                         : OBI grant
//   instr_rvalid_o, instr_rdata_o,
//   instr_err_o                         : OBI response (err for out-of-range addresses)
//   stall_en_i                          : enables random grant stalls
//   ram_en_o, ram_addr_o, ram_rdata_i   : RAM port A (read data registered, 1-cycle latency)
//   gnt_count_o                         : number of grants, wrapping
// Handshake: a request is accepted in every cycle with req & gnt. Its response appears
// with rvalid exactly one cycle later. There is no rready, so responses never back up
// and a new grant is always legal; back-to-back grants yield back-to-back rvalids.
module obi_instr_fetch_bridge
  import tb_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH        = 22,
  parameter int unsigned INSTR_RDATA_WIDTH = 128,
  parameter int unsigned MAX_STALL         = 3,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         instr_req_i,
  input  logic [31:0]                  instr_addr_i,
  output logic                         instr_gnt_o,
  output logic                         instr_rvalid_o,
  output logic [31:0]                  instr_rdata_o,
  output logic                         instr_err_o,
  input  logic                         stall_en_i,
  output logic                         ram_en_o,
  output logic [ADDR_WIDTH-1:0]        ram_addr_o,
  input  logic [INSTR_RDATA_WIDTH-1:0] ram_rdata_i,
  output logic [31:0]                  gnt_count_o
);

  logic                         stall_now;
  logic                         gnt;
  logic                         oor;
  logic [ADDR_WIDTH-1:0]        gnt_addr;
  logic [ADDR_WIDTH-1:0]        ram_addr_q;
  logic                         rsp_valid_q, rsp_a1_q, rsp_oor_q;
  logic [31:0]                  rdata_hold_q;
  logic [31:0]                  gnt_count_q, gnt_count_d;
  logic [INSTR_RDATA_WIDTH-1:0] line_shifted;
  obi_fetch_rsp_t               rsp;

  tb_stall_lfsr #(
    .MAX_STALL (MAX_STALL),
    .LFSR_SEED (LFSR_SEED)
  ) u_stall (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .stall_en_i  (stall_en_i),
    .req_i       (instr_req_i),
    .stall_now_o (stall_now)
  );

  assign gnt         = instr_req_i & ~stall_now;
  // Word-aligned line address; bit 1 is remembered to pick the slice, bit 0 is ignored.
  assign gnt_addr    = {instr_addr_i[ADDR_WIDTH-1:2], 2'b00};
  // 33-bit compare so ADDR_WIDTH = 32 still works.
  assign oor         = {1'b0, instr_addr_i} >= (33'd1 << ADDR_WIDTH);
  assign gnt_count_d = gnt_count_q + 32'd1;

  always_comb begin
    rsp          = '0;
    rsp.gnt      = gnt;
    rsp.rvalid   = rsp_valid_q;
    rsp.err      = rsp_valid_q & rsp_oor_q;
    line_shifted = ram_rdata_i >> line_slice_offset(rsp_a1_q);
    if (rsp_valid_q) begin
      rsp.rdata = rsp_oor_q ? 32'h0000_0000 : line_shifted[31:0];
    end else begin
      rsp.rdata = rdata_hold_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ram_addr_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_a1_q     <= 1'b0;
      rsp_oor_q    <= 1'b0;
      rdata_hold_q <= 32'h0;
      gnt_count_q  <= 32'h0;
    end else begin
      rsp_valid_q <= gnt;
      if (gnt) begin
        ram_addr_q  <= gnt_addr;
        rsp_a1_q    <= instr_addr_i[1];
        rsp_oor_q   <= oor;
        gnt_count_q <= gnt_count_d;
      end
      if (rsp_valid_q) begin
        rdata_hold_q <= rsp.rdata;
      end
    end
  end

  assign instr_gnt_o    = rsp.gnt;
  assign instr_rvalid_o = rsp.rvalid;
  assign instr_rdata_o  = rsp.rdata;
  assign instr_err_o    = rsp.err;
  assign ram_en_o       = gnt;
  assign ram_addr_o     = gnt ? gnt_addr : ram_addr_q;
  assign gnt_count_o    = gnt_count_q;

`ifndef SYNTHESIS
  // Fetch addresses must be halfword aligned.
  addr_halfword_aligned_a : assert property (
    @(posedge clk_i) disable iff (rst_i) instr_req_i |-> !instr_addr_i[0]
  );
`endif

endmodule

// File: tb/tb_obi_instr_fetch_bridge.sv
module tb_obi_instr_fetch_bridge;
  localparam int          AW        = 22;
  localparam int          RW        = 128;
  localparam int          MAX_STALL = 3;
  localparam logic [15:0] SEED      = 16'hACE1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [31:0]   addr;
  logic          gnt, rvalid, err, ram_en, stall_en;
  logic [31:0]   rdata, gnt_count;
  logic [AW-1:0] ram_addr;
  logic [RW-1:0] ram_rdata = '0;

  always #5 clk = ~clk;

  obi_instr_fetch_bridge #(
    .ADDR_WIDTH (AW), .INSTR_RDATA_WIDTH (RW), .MAX_STALL (MAX_STALL), .LFSR_SEED (SEED)
  ) dut (
    .clk_i (clk), .rst_i (rst),
    .instr_req_i (req), .instr_addr_i (addr), .instr_gnt_o (gnt),
    .instr_rvalid_o (rvalid), .instr_rdata_o (rdata), .instr_err_o (err),
    .stall_en_i (stall_en),
    .ram_en_o (ram_en), .ram_addr_o (ram_addr), .ram_rdata_i (ram_rdata),
    .gnt_count_o (gnt_count)
  );

  // ---------------- RAM model: byte array, registered line read every edge ----------------
  logic [7:0] mem [0:4095];

  function automatic logic [7:0] rd(input logic [31:0] a);
    return mem[a[11:0]];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < RW / 8; i++) ram_rdata[8*i +: 8] <= rd(32'(ram_addr) + 32'(i));
  end

  // ---------------- reference model: the fetch word at a byte address ----------------
  function automatic logic [32:0] model_word(input logic [31:0] a);
    if (a >= 32'h0040_0000) return {1'b1, 32'h0};
    return {1'b0, rd(a + 3), rd(a + 2), rd(a + 1), rd(a)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int checks = 0, failures = 0;
  int gnt_model = 0, rv_cnt = 0, stall_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: response timing, data/err against queue, hold value when idle.
  logic [31:0] last_data = 32'h0;
  logic        prev_gnt  = 1'b0;
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      last_data = 32'h0;
      prev_gnt  = 1'b0;
    end else begin
      chk("rvalid_timing", 64'(rvalid), 64'(prev_gnt));
      if (rvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rdata", 64'(rdata), 64'(e[31:0]));
          chk("err", 64'(err), 64'(e[32]));
        end
        last_data = rdata;
        rv_cnt++;
      end else begin
        chk("rdata_hold", 64'(rdata), 64'(last_data));
        chk("err_idle", 64'(err), 64'(0));
      end
      prev_gnt = gnt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fetch(input logic [31:0] a, input bit directed, input logic [32:0] dexp);
    int  waits = 0;
    bit  done  = 0;
    logic [AW-1:0] exp_ra;
    req  = 1'b1;
    addr = a;
    exp_ra = {a[AW-1:2], 2'b00};
    while (!done) begin
      @(negedge clk);
      if (gnt) begin
        chk("ram_addr", 64'(ram_addr), 64'(exp_ra));
        chk("ram_en", 64'(ram_en), 64'(1));
        chk("stall_gap", 64'(waits <= MAX_STALL), 64'(1));
        exp_q.push_back(directed ? dexp : model_word(a));
        gnt_model++;
        done = 1;
      end else begin
        waits++;
        stall_total++;
        if (waits > 20) begin
          chk("gnt_timeout", 64'(0), 64'(1));
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return ($urandom() | 32'h0040_0000) & ~32'h1;
    return {10'd0, 21'($urandom_range(0, 32'h1F_FFFF)), 1'b0};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int rv0, g0, cnt;
    logic [15:0] lfsr;
    bit exp_gnt;

    rst = 1'b1; req = 1'b0; addr = 32'h0; stall_en = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom());
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_ram_en", 64'(ram_en), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_ram_addr", 64'(ram_addr), 64'(0));
    chk("rst_gnt_count", 64'(gnt_count), 64'(0));
    @(posedge clk); #1; rst = 1'b0;

    // Back-to-back aligned fetches.
    {mem[0], mem[1], mem[2], mem[3]} = {8'h93, 8'h00, 8'h10, 8'h00};
    {mem[4], mem[5], mem[6], mem[7]} = {8'h13, 8'h00, 8'h00, 8'h00};
    fetch(32'h0, 1, {1'b0, 32'h0010_0093});
    fetch(32'h4, 1, {1'b0, 32'h0000_0013});
    idle(3);
    chk("gnt_count_two", 64'(gnt_count), 64'(2));

    // Misaligned fetch spanning two words of one line.
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h11 * (i + 1));
    fetch(32'h2, 1, {1'b0, 32'h6655_4433});
    idle(2);
    chk("ram_addr_hold", 64'(ram_addr), 64'(0));

    // Out-of-range, then an in-range fetch.
    fetch(32'h0040_0000, 1, {1'b1, 32'h0});
    fetch(32'h0000_0008, 1, {1'b0, mem[11], mem[10], mem[9], mem[8]});
    idle(2);

    // Random fetches without stalls.
    for (int n = 0; n < 200; n++) begin
      fetch(rand_addr(), 0, '0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    chk("gnt_count_rand", 64'(gnt_count), 64'(gnt_model));

    // Stall bound with random stalls.
    stall_en = 1'b1;
    rv0 = rv_cnt; g0 = gnt_model; stall_total = 0;
    for (int n = 0; n < 1000; n++) begin
      fetch(rand_addr(), 0, '0);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(3);
    chk("stall_seen", 64'(stall_total > 0), 64'(1));
    chk("rv_eq_gnt", 64'(rv_cnt - rv0), 64'(gnt_model - g0));
    chk("gnt_count_stall", 64'(gnt_count), 64'(gnt_model));
    stall_en = 1'b0;

    // Reset right after a grant: the pending response is dropped.
    fetch(32'h10, 0, '0);
    rst = 1'b1; req = 1'b1; addr = 32'h0; stall_en = 1'b1;
    exp_q.delete();
    gnt_model = 0;
    @(negedge clk);
    chk("rst_mid_rvalid", 64'(rvalid), 64'(0));
    chk("rst_mid_count", 64'(gnt_count), 64'(0));
    @(posedge clk); #1; rst = 1'b0;

    // Post-reset stall pattern from the seed, request held continuously.
    lfsr = SEED; cnt = 0;
    for (int n = 0; n < 24; n++) begin
      exp_gnt = !(lfsr[0] && cnt < MAX_STALL);
      @(negedge clk);
      chk("stall_pattern", 64'(gnt), 64'(exp_gnt));
      if (gnt) begin
        exp_q.push_back(model_word(32'h0));
        gnt_model++;
      end
      cnt  = exp_gnt ? 0 : cnt + 1;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      @(posedge clk); #1;
    end
    stall_en = 1'b0;
    idle(3);
    chk("gnt_count_post_rst", 64'(gnt_count), 64'(gnt_model));

    // Grant counter wrap.
    force dut.gnt_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.gnt_count_q;
    @(negedge clk);
    chk("count_preset", 64'(gnt_count), 64'(32'hFFFF_FFFF));
    @(posedge clk); #1;
    fetch(32'h20, 0, '0);
    idle(2);
    chk("count_wrap", 64'(gnt_count), 64'(0));

    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the run must always end.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
